// File: rtl/sp_port_dispatcher_pkg.sv
// sp_port_dispatcher_pkg: default parameters and the illegal port-id check shared
// with the qsch arbiter family.
package sp_port_dispatcher_pkg;
    localparam int DEF_REQ_NUMB      = 4;
    localparam int DEF_ID_BITWIDTH   = 2;
    localparam int DEF_DATA_BITWIDTH = 10;
    localparam int DEF_CNT_BITWIDTH  = 16;

    function automatic logic id_illegal(input int unsigned id, input int unsigned req_numb);
        return id >= req_numb;
    endfunction
endpackage

// File: rtl/sp_skid_buf.sv
// sp_skid_buf: two-entry input skid buffer (head + skid) with a registered ready.
module sp_skid_buf #(
    parameter int WIDTH = 12
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_vld_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_rdy_o,
    output logic             out_vld_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_rdy_i
);
    logic             head_vld_q, head_vld_d, skid_vld_q, skid_vld_d, rdy_q;
    logic [WIDTH-1:0] head_q, head_d, skid_q, skid_d;
    logic             in_fire, out_fire;

    assign in_fire    = in_vld_i & rdy_q;
    assign out_fire   = head_vld_q & out_rdy_i;
    assign in_rdy_o   = rdy_q;
    assign out_vld_o  = head_vld_q;
    assign out_data_o = head_q;

    // Ready is only high while the skid entry is empty, so a pop never coincides
    // with a full skid and an incoming beat.
    always_comb begin
        head_vld_d = head_vld_q;
        head_d     = head_q;
        skid_vld_d = skid_vld_q;
        skid_d     = skid_q;
        if (out_fire) begin
            head_vld_d = skid_vld_q | in_fire;
            head_d     = skid_vld_q ? skid_q : in_data_i;
            skid_vld_d = 1'b0;
        end else if (in_fire) begin
            if (head_vld_q) begin
                skid_vld_d = 1'b1;
                skid_d     = in_data_i;
            end else begin
                head_vld_d = 1'b1;
                head_d     = in_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            head_q     <= '0;
            skid_q     <= '0;
            rdy_q      <= 1'b0;
        end else begin
            head_vld_q <= head_vld_d;
            skid_vld_q <= skid_vld_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            rdy_q      <= ~skid_vld_d;
        end
    end
endmodule

// File: rtl/sp_port_dispatcher.sv
// sp_port_dispatcher: routes an in-order beat stream to per-port output registers,
// dropping and counting beats addressed to nonexistent ports.
module sp_port_dispatcher
    import sp_port_dispatcher_pkg::*;
#(
    parameter int REQ_NUMB      = DEF_REQ_NUMB,
    parameter int ID_BITWIDTH   = DEF_ID_BITWIDTH,
    parameter int DATA_BITWIDTH = DEF_DATA_BITWIDTH,
    parameter int CNT_BITWIDTH  = DEF_CNT_BITWIDTH
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     RxVld,
    input  logic [DATA_BITWIDTH-1:0] RxData,
    input  logic [ID_BITWIDTH-1:0]   RxPortId,
    output logic                     RxRdy,
    output logic [REQ_NUMB-1:0]      TxVld,
    output logic [DATA_BITWIDTH-1:0] TxData [REQ_NUMB],
    input  logic [REQ_NUMB-1:0]      TxRdy,
    output logic [CNT_BITWIDTH-1:0]  DropCnt
);
    localparam int BW = ID_BITWIDTH + DATA_BITWIDTH;

    logic                     head_vld, pop, illegal;
    logic [BW-1:0]            head;
    logic [ID_BITWIDTH-1:0]   head_id;
    logic [DATA_BITWIDTH-1:0] head_data;
    logic [REQ_NUMB-1:0]      load, vld_q, vld_d;
    logic [DATA_BITWIDTH-1:0] dat_q [REQ_NUMB];
    logic [CNT_BITWIDTH-1:0]  drop_q, drop_d;

    sp_skid_buf #(.WIDTH(BW)) u_skid (
        .clk_i     (sys_clk),
        .rst_i     (rst),
        .in_vld_i  (RxVld),
        .in_data_i ({RxPortId, RxData}),
        .in_rdy_o  (RxRdy),
        .out_vld_o (head_vld),
        .out_data_o(head),
        .out_rdy_i (pop)
    );

    assign {head_id, head_data} = head;
    assign illegal = id_illegal(32'(head_id), REQ_NUMB);

    // A port register accepts the head when empty or draining on the same edge.
    for (genvar p = 0; p < REQ_NUMB; p++) begin : g_port
        assign load[p]  = head_vld & ~illegal & (head_id == ID_BITWIDTH'(p)) & (~vld_q[p] | TxRdy[p]);
        assign vld_d[p] = load[p] | (vld_q[p] & ~TxRdy[p]);
    end

    assign pop     = (head_vld & illegal) | (|load);
    assign drop_d  = (head_vld & illegal & ~&drop_q) ? drop_q + 1'b1 : drop_q;
    assign TxVld   = vld_q;
    assign TxData  = dat_q;
    assign DropCnt = drop_q;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            drop_q <= '0;
            for (int i = 0; i < REQ_NUMB; i++) dat_q[i] <= '0;
        end else begin
            vld_q  <= vld_d;
            drop_q <= drop_d;
            for (int i = 0; i < REQ_NUMB; i++) if (load[i]) dat_q[i] <= head_data;
        end
    end
endmodule

// File: tb/tb_sp_port_dispatcher.sv
// tb_sp_port_dispatcher: directed and random checks against a queue-based reference model.
module tb_sp_port_dispatcher;
    localparam int N = 4;
    localparam int W = 10;

    logic         sys_clk = 1'b0;
    logic         rst = 1'b0;
    logic         rx_vld = 1'b0;
    logic [W-1:0] rx_data = '0;
    logic [1:0]   rx_id = '0;
    logic         rx_rdy;
    logic [N-1:0] tx_vld;
    logic [N-1:0] tx_rdy = '0;
    logic [W-1:0] tx_data [N];
    logic [15:0]  drop_cnt;

    logic         b_vld = 1'b0;
    logic [W-1:0] b_data = '0;
    logic [1:0]   b_id = '0;
    logic         b_rdy;
    logic [2:0]   b_txvld;
    logic [2:0]   b_txrdy = '1;
    logic [W-1:0] b_txdata [3];
    logic [2:0]   b_drop;

    sp_port_dispatcher dut (
        .sys_clk(sys_clk), .rst(rst), .RxVld(rx_vld), .RxData(rx_data), .RxPortId(rx_id),
        .RxRdy(rx_rdy), .TxVld(tx_vld), .TxData(tx_data), .TxRdy(tx_rdy), .DropCnt(drop_cnt)
    );

    sp_port_dispatcher #(.REQ_NUMB(3), .CNT_BITWIDTH(3)) dut_b (
        .sys_clk(sys_clk), .rst(rst), .RxVld(b_vld), .RxData(b_data), .RxPortId(b_id),
        .RxRdy(b_rdy), .TxVld(b_txvld), .TxData(b_txdata), .TxRdy(b_txrdy), .DropCnt(b_drop)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {logic [1:0] id; logic [W-1:0] d;} beat_t;

    int           total = 0, bad = 0, acc = 0;
    beat_t        mq[$];
    logic         m_rdy;
    logic [N-1:0] m_vld;
    logic [W-1:0] m_dat [N];
    int           m_drop;
    logic [W-1:0] sb [N][$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rdy  = 1'b0;
        m_vld  = '0;
        m_drop = 0;
        for (int p = 0; p < N; p++) begin
            m_dat[p] = '0;
            sb[p].delete();
        end
    endtask

    // Called at a negedge with inputs already driven; advances one clock.
    task automatic step();
        logic  take;
        beat_t h;
        take = rx_vld && m_rdy;
        if (take) begin
            sb[rx_id].push_back(rx_data);
            acc++;
        end
        for (int p = 0; p < N; p++) if (tx_vld[p] && tx_rdy[p]) begin
            if (sb[p].size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_extra port %0d: got beat %0h want none", p, tx_data[p]);
            end else chk($sformatf("sb_port%0d", p), 32'(tx_data[p]), 32'(sb[p].pop_front()));
        end
        @(posedge sys_clk);
        for (int p = 0; p < N; p++) if (m_vld[p] && tx_rdy[p]) m_vld[p] = 1'b0;
        if (mq.size() > 0 && !m_vld[mq[0].id]) begin
            h = mq.pop_front();
            m_vld[h.id] = 1'b1;
            m_dat[h.id] = h.d;
        end
        if (take) mq.push_back({rx_id, rx_data});
        m_rdy = mq.size() < 2;
        @(negedge sys_clk);
        chk("rx_rdy", 32'(rx_rdy), 32'(m_rdy));
        chk("tx_vld", 32'(tx_vld), 32'(m_vld));
        for (int p = 0; p < N; p++) chk($sformatf("tx_data%0d", p), 32'(tx_data[p]), 32'(m_dat[p]));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    endtask

    task automatic send(input logic [1:0] id, input logic [W-1:0] d);
        rx_vld  = 1'b1;
        rx_id   = id;
        rx_data = d;
        step();
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b1;
        #2;
        chk("rst_rx_rdy", 32'(rx_rdy), 0);
        chk("rst_tx_vld", 32'(tx_vld), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        chk("rst_tx_data", 32'(tx_data[2]), 0);
        @(negedge sys_clk) rst = 1'b0;
        step();
        chk("rdy_after_rst", 32'(rx_rdy), 1);

        // back-to-back beats round-robin over all ports
        tx_rdy = '1;
        for (int i = 0; i < 8; i++) begin
            send(2'(i % 4), 10'(32'h100 + i));
            if (i > 0) begin
                chk("rr_vld", 32'(tx_vld), 32'(1 << ((i - 1) % 4)));
                chk("rr_data", 32'(tx_data[(i - 1) % 4]), 32'h100 + i - 1);
            end else chk("rr_lat", 32'(tx_vld), 0);
        end
        rx_vld = 1'b0;
        step();
        chk("rr_last", 32'(tx_vld), 32'h8);
        chk("rr_last_d", 32'(tx_data[3]), 32'h107);
        step();

        // blocked port 2 with three beats queued
        tx_rdy = 4'b1011;
        send(2, 10'hA);
        send(2, 10'hB);
        send(2, 10'hC);
        chk("blk_rdy_low", 32'(rx_rdy), 0);
        rx_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("blk_hold", 32'(tx_data[2]), 32'hA);
            chk("blk_vld", 32'(tx_vld[2]), 1);
        end
        tx_rdy = '1;
        step();
        chk("blk_b", 32'(tx_data[2]), 32'hB);
        chk("blk_rdy_up", 32'(rx_rdy), 1);
        step();
        chk("blk_c", 32'(tx_data[2]), 32'hC);
        step();
        chk("blk_empty", 32'(tx_vld[2]), 0);

        // head-of-line: port 3 beat waits behind blocked port 1
        tx_rdy = 4'b1101;
        send(1, 10'h11);
        send(1, 10'h12);
        send(3, 10'h33);
        rx_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hol_p3_idle", 32'(tx_vld[3]), 0);
        end
        tx_rdy = '1;
        step();
        chk("hol_p3_still", 32'(tx_vld[3]), 0);
        chk("hol_p1_next", 32'(tx_data[1]), 32'h12);
        step();
        chk("hol_p3_go", 32'(tx_vld[3]), 1);
        chk("hol_p3_d", 32'(tx_data[3]), 32'h33);
        step();

        // illegal ids on the 3-port instance, counter saturating at 7
        b_vld = 1'b1;
        b_id  = 2'd3;
        for (int k = 1; k <= 10; k++) begin
            b_data = 10'($urandom);
            step();
            chk("b_no_tx", 32'(b_txvld), 0);
            chk("b_drop", 32'(b_drop), (k - 1 > 7) ? 7 : k - 1);
        end
        b_id   = 2'd1;
        b_data = 10'h155;
        step();
        b_vld = 1'b0;
        step();
        chk("b_legal_vld", 32'(b_txvld), 32'h2);
        chk("b_legal_d", 32'(b_txdata[1]), 32'h155);
        chk("b_drop_sat", 32'(b_drop), 7);

        // asynchronous reset with beats buffered
        tx_rdy = '0;
        send(0, 10'h21);
        send(0, 10'h22);
        send(0, 10'h23);
        chk("ar_full", 32'(rx_rdy), 0);
        rx_vld = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("ar_tx_vld", 32'(tx_vld), 0);
        chk("ar_rx_rdy", 32'(rx_rdy), 0);
        model_reset();
        @(negedge sys_clk) rst = 1'b0;
        tx_rdy = '1;
        for (int i = 0; i < 3; i++) step();
        chk("ar_no_ghost", 32'(tx_vld), 0);

        // random traffic
        acc = 0;
        for (int cyc = 0; acc < 10000 && cyc < 60000; cyc++) begin
            rx_vld  = ($urandom % 4) != 0;
            rx_id   = 2'($urandom);
            rx_data = 10'($urandom);
            for (int p = 0; p < N; p++) tx_rdy[p] = ($urandom % 10) < 7;
            step();
        end
        total++;
        if (acc < 10000) begin
            bad++;
            $display("FAIL rand_budget: got %0d beats want 10000", acc);
        end
        rx_vld = 1'b0;
        tx_rdy = '1;
        for (int i = 0; i < 6; i++) step();
        for (int p = 0; p < N; p++) chk($sformatf("sb_left%0d", p), sb[p].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sp_port_dispatcher.md
SP_PORT_DISPATCHER -- requirements
Module: sp_port_dispatcher

Interface
REQ-001 Parameter REQ_NUMB, default 4, number of output ports.
REQ-002 Parameter ID_BITWIDTH, default 2, width of port-id field.
REQ-003 Parameter DATA_BITWIDTH, default 10, beat payload width.
REQ-004 Parameter CNT_BITWIDTH, default 16, drop-counter width.
REQ-005 sys_clk  input  1  sole clock, all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 RxVld  input  1  upstream beat valid.
REQ-008 RxData  input  DATA_BITWIDTH  upstream payload.
REQ-009 RxPortId  input  ID_BITWIDTH  destination port of beat.
REQ-010 RxRdy  output  1  upstream ready, driven directly from a flop.
REQ-011 TxVld  output  REQ_NUMB  per-port valid.
REQ-012 TxData  output  DATA_BITWIDTH x REQ_NUMB (unpacked array)  per-port payload.
REQ-013 TxRdy  input  REQ_NUMB  per-port downstream ready.
REQ-014 DropCnt  output  CNT_BITWIDTH  count of beats discarded for illegal port id.

Function
REQ-015 Transfer occurs on any edge where valid and ready are both high, on Rx and on each Tx port independently.
REQ-016 Input stage SHALL be a 2-entry skid buffer (main + skid); RxRdy=1 when skid entry empty, registered.
REQ-017 Each port p SHALL own one output register; TxVld[p]/TxData[p] come straight from it.
REQ-018 Head beat of skid buffer SHALL move to port RxPortId register on an edge where that register is empty or TxRdy[p]=1.
REQ-019 Latency: beat accepted on edge k SHALL assert TxVld[p] after edge k+1 when the path is free.
REQ-020 Throughput: one beat/cycle sustained, including back-to-back to one port, while TxRdy[p]=1.
REQ-021 Order SHALL be preserved globally; blocked head stalls all later beats (head-of-line blocking, no bypass).
REQ-022 TxVld[p] once high SHALL hold, with TxData[p] stable, until TxRdy[p]=1.
REQ-023 TxVld/TxData SHALL NOT depend combinationally on TxRdy or Rx inputs.
REQ-024 Beat with RxPortId >= REQ_NUMB SHALL be accepted, dropped when at head (one cycle, no Tx activity), and increment DropCnt.
REQ-025 DropCnt SHALL saturate at all-ones.
REQ-026 Simultaneous Tx drain and refill of the same port register on one edge SHALL keep TxVld[p]=1 with new data.
REQ-027 Skid full (2 beats held) SHALL drop RxRdy on next edge; RxRdy SHALL rise the edge after head leaves.
REQ-028 Data presented with RxRdy=0 SHALL be ignored.

Reset
REQ-029 rst high SHALL immediately clear: RxRdy=0, TxVld=0, DropCnt=0, skid buffer empty.
REQ-030 RxRdy SHALL rise on the first edge after rst deasserts.
REQ-031 TxData reset value 0; beats in flight at reset are discarded, never delivered.

Structure
REQ-032 Shared defs header SHALL hold default parameter constants and the illegal-port-id check macro, common with the qsch arbiter family.
REQ-033 Input stage SHALL be sub-module sp_skid_buf (parameterised width, carries {RxPortId, RxData}).
REQ-034 Target RTL size 120-400 lines.

Verification
REQ-035 Reset then 8 beats id 0..3 repeating, all TxRdy=1 -> each port gets 2 beats in order, first TxVld after 2 edges, no bubbles.
REQ-036 Beats 0xA,0xB,0xC to port 2 with TxRdy[2]=0 for 5 cycles -> TxData[2]=0xA held, RxRdy falls after 3rd beat, 0xB,0xC delivered in order after release.
REQ-037 Port 1 blocked, next beat for port 3 -> port 3 stays idle until port 1 drains (HOL ordering).
REQ-038 REQ_NUMB=3, beat with id 3 -> no TxVld, DropCnt 0->1; DropCnt preset near max saturates at all-ones.
REQ-039 rst asserted mid-stream with 2 beats buffered -> all TxVld low asynchronously, buffered beats never appear after reset.
REQ-040 Random valid/ready on all ports, 10k beats -> scoreboard shows no loss, duplication, or reorder per port.
